// File: rtl/pxconv_pkg.sv
// Shared constants and helpers for the pixel converter / line buffer.
package pxconv_pkg;

  localparam int MODE_MEAN = 0;
  localparam int MODE_LUMA = 1;
  localparam int MODE_GREY = 2;

  localparam logic [7:0] W_R    = 8'd77;
  localparam logic [7:0] W_G    = 8'd150;
  localparam logic [7:0] W_B    = 8'd29;
  localparam logic [7:0] MEAN_K = 8'd171;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pxconv_grey.sv
// Two-stage conversion of a 16-bit input pixel to 8-bit grey.
module pxconv_grey import pxconv_pkg::*; #(
  parameter int MODE = MODE_MEAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  logic [15:0] in_data,
  output logic        out_vld,
  output logic [7:0]  out_grey
);

  logic [7:0]  r8, g8, b8;
  logic [15:0] acc_p1_d, acc_p1_q;
  logic        vld_p1_q;
  logic [16:0] mean_prod;
  logic [7:0]  grey_p2_d, grey_p2_q;
  logic        vld_p2_q;

  assign r8 = {in_data[15:11], 3'b000};
  assign g8 = {in_data[10:5], 2'b00};
  assign b8 = {in_data[4:0], 3'b000};

  // Stage 1: channel sum or weighted accumulation
  always_comb begin
    acc_p1_d = '0;
    case (MODE)
      MODE_MEAN: acc_p1_d = {6'b0, 10'(r8) + 10'(g8) + 10'(b8)};
      MODE_LUMA: acc_p1_d = 16'(r8) * 16'(W_R) + 16'(g8) * 16'(W_G) + 16'(b8) * 16'(W_B);
      default:   acc_p1_d = {8'b0, in_data[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      acc_p1_q <= acc_p1_d;
      vld_p1_q <= in_vld;
    end
  end

  // Stage 2: scale down to 8 bits; (sum*171)>>9 approximates sum/3
  assign mean_prod = 17'(acc_p1_q[9:0]) * 17'(MEAN_K);

  always_comb begin
    grey_p2_d = '0;
    case (MODE)
      MODE_MEAN: grey_p2_d = 8'(mean_prod >> 9);
      MODE_LUMA: grey_p2_d = acc_p1_q[15:8];
      default:   grey_p2_d = acc_p1_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grey_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      grey_p2_q <= grey_p2_d;
      vld_p2_q  <= vld_p1_q;
    end
  end

  assign out_vld  = vld_p2_q;
  assign out_grey = grey_p2_q;

endmodule

// File: rtl/pxconv_lbuf.sv
// Pixel converter feeding a ring line buffer with burst reservation and line accounting.
module pxconv_lbuf import pxconv_pkg::*; #(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int NLINES = 8,
  parameter int BURST  = 128,
  parameter int MODE   = MODE_MEAN,
  parameter int AW     = clog2(NLINES * HRES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  pix_data,
  input  logic                         pix_valid,
  output logic                         rd_req,
  output logic [11:0]                  rd_len,
  input  logic                         rd_ack,
  input  logic                         line_release,
  output logic                         bram_we,
  output logic [AW-1:0]                bram_addr,
  output logic [7:0]                   bram_data,
  output logic [clog2(NLINES+1)-1:0]   lines_filled,
  output logic                         wnd_in_bram,
  output logic                         frame_done,
  output logic                         err_ovf
);

  localparam int DEPTH = NLINES * HRES;
  localparam int LW    = clog2(NLINES + 1);
  localparam int OW    = clog2(DEPTH + 1) + 1;
  localparam int TOTAL = HRES * VRES / BURST;
  localparam int RW    = clog2(TOTAL + 1);
  localparam int CW    = (HRES > 1) ? clog2(HRES) : 1;
  localparam int VW    = (VRES > 1) ? clog2(VRES) : 1;

  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] col_q, col_d;
  logic [VW-1:0] row_q, row_d;
  logic [LW-1:0] lines_q, lines_d;
  logic [OW-1:0] occ_q, occ_d, resv_q, resv_d;
  logic [RW-1:0] reqs_q, reqs_d;
  logic          rd_req_q, rd_req_d;
  logic          err_q, err_d;

  logic hs, accept, we, last_col, last_row, line_done, frame_end, rel_ok;

  assign hs        = rd_req_q & rd_ack;
  assign accept    = pix_valid & (resv_q != '0);
  assign last_col  = (col_q == CW'(HRES - 1));
  assign last_row  = (row_q == VW'(VRES - 1));
  assign line_done = we & last_col;
  assign frame_end = line_done & last_row;
  assign rel_ok    = line_release & (lines_q != '0);

  pxconv_grey #(.MODE(MODE)) u_grey (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (accept),
    .in_data  (pix_data),
    .out_vld  (we),
    .out_grey (bram_data)
  );

  always_comb begin
    addr_d   = addr_q;
    col_d    = col_q;
    row_d    = row_q;
    lines_d  = lines_q;
    if (we) begin
      addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
      col_d  = last_col ? '0 : col_q + CW'(1);
    end
    if (line_done) row_d = last_row ? '0 : row_q + VW'(1);
    case ({line_done, rel_ok})
      2'b10:   lines_d = lines_q + LW'(1);
      2'b01:   lines_d = lines_q - LW'(1);
      default: lines_d = lines_q;
    endcase
    // Handshake, release and arrival may coincide; apply them as one net change
    occ_d    = occ_q + (hs ? OW'(BURST) : '0) - (rel_ok ? OW'(HRES) : '0);
    resv_d   = resv_q + (hs ? OW'(BURST) : '0) - (accept ? OW'(1) : '0);
    reqs_d   = frame_end ? RW'(TOTAL) : reqs_q - (hs ? RW'(1) : '0);
    rd_req_d = !hs && (occ_q + OW'(BURST) <= OW'(DEPTH)) && (reqs_q != '0);
    err_d    = err_q | (pix_valid & ~accept) | (line_release & (lines_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      lines_q  <= '0;
      occ_q    <= '0;
      resv_q   <= '0;
      reqs_q   <= RW'(TOTAL);
      rd_req_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      lines_q  <= lines_d;
      occ_q    <= occ_d;
      resv_q   <= resv_d;
      reqs_q   <= reqs_d;
      rd_req_q <= rd_req_d;
      err_q    <= err_d;
    end
  end

  assign rd_req       = rd_req_q;
  assign rd_len       = 12'(BURST);
  assign bram_we      = we;
  assign bram_addr    = addr_q;
  assign lines_filled = lines_q;
  assign wnd_in_bram  = (lines_q == LW'(NLINES));
  assign frame_done   = frame_end;
  assign err_ovf      = err_q;

endmodule

// File: tb/tb_pxconv_lbuf.sv
// Bench for pxconv_lbuf: conversion table, directed corner sequences and a randomized run against a queue-based model.
module tb_pxconv_lbuf;

  localparam int HRES = 16, VRES = 4, NLINES = 2, BURST = 8;
  localparam int DEPTH = NLINES * HRES;
  localparam int TOTAL = HRES * VRES / BURST;
  localparam int AW = 5, LW = 2;

  logic clk = 1'b0;
  logic rst_n, pix_valid, rd_ack, line_release;
  logic [15:0] pix_data;

  logic          rd_req0, rd_req1, rd_req2;
  logic [11:0]   rd_len0, rd_len1, rd_len2;
  logic          we0, we1, we2;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [7:0]    data0, data1, data2;
  logic [LW-1:0] lines0, lines1, lines2;
  logic          wnd0, wnd1, wnd2, fd0, fd1, fd2, err0, err1, err2;

  always #5 clk = ~clk;

  pxconv_lbuf #(.HRES(HRES), .VRES(VRES), .NLINES(NLINES), .BURST(BURST), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .rd_req(rd_req0), .rd_len(rd_len0), .rd_ack(rd_ack), .line_release(line_release),
    .bram_we(we0), .bram_addr(addr0), .bram_data(data0), .lines_filled(lines0),
    .wnd_in_bram(wnd0), .frame_done(fd0), .err_ovf(err0));
  pxconv_lbuf #(.HRES(HRES), .VRES(VRES), .NLINES(NLINES), .BURST(BURST), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .rd_req(rd_req1), .rd_len(rd_len1), .rd_ack(rd_ack), .line_release(line_release),
    .bram_we(we1), .bram_addr(addr1), .bram_data(data1), .lines_filled(lines1),
    .wnd_in_bram(wnd1), .frame_done(fd1), .err_ovf(err1));
  pxconv_lbuf #(.HRES(HRES), .VRES(VRES), .NLINES(NLINES), .BURST(BURST), .MODE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .rd_req(rd_req2), .rd_len(rd_len2), .rd_ack(rd_ack), .line_release(line_release),
    .bram_we(we2), .bram_addr(addr2), .bram_data(data2), .lines_filled(lines2),
    .wnd_in_bram(wnd2), .frame_done(fd2), .err_ovf(err2));

  int n_checks = 0, n_err = 0;

  typedef struct { int due; int g0; int g1; int g2; } wr_t;
  wr_t wq[$];
  int cyc = 0;
  int m_occ, m_resv, m_reqs, m_lines, m_addr, m_col, m_row, m_frames;
  bit m_rdreq, m_err;
  int hs_cnt = 0, dut_frames = 0;

  typedef struct { logic [15:0] pix; logic [7:0] e0; logic [7:0] e1; logic [7:0] e2; } vec_t;
  vec_t tab[7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_grey(input int mode, input int d);
    int r, g, b;
    r = ((d >> 11) % 32) * 8;
    g = ((d >> 5) % 64) * 4;
    b = (d % 32) * 8;
    case (mode)
      0:       return (r + g + b) * 171 / 512;
      1:       return (77 * r + 150 * g + 29 * b) / 256;
      default: return d % 256;
    endcase
  endfunction

  task automatic model_reset();
    wq.delete();
    m_occ = 0; m_resv = 0; m_reqs = TOTAL; m_lines = 0;
    m_addr = 0; m_col = 0; m_row = 0; m_rdreq = 0; m_err = 0;
  endtask

  function automatic bit write_now();
    return rst_n && (wq.size() > 0) && (wq[0].due == cyc);
  endfunction

  task automatic check_outputs();
    bit ew;
    ew = write_now();
    chk("rd_req", int'(rd_req0), int'(m_rdreq));
    chk("bram_we", int'(we0), int'(ew));
    if (ew) begin
      chk("bram_addr", int'(addr0), m_addr);
      chk("grey_mean", int'(data0), wq[0].g0);
      chk("grey_luma", int'(data1), wq[0].g1);
      chk("grey_pass", int'(data2), wq[0].g2);
    end
    chk("lines_filled", int'(lines0), m_lines);
    chk("wnd_in_bram", int'(wnd0), int'(m_lines == NLINES));
    chk("frame_done", int'(fd0), int'(ew && m_col == HRES - 1 && m_row == VRES - 1));
    chk("err_ovf", int'(err0), int'(m_err));
    if (fd0) dut_frames++;
  endtask

  task automatic tick();
    bit hs, wr, ld, fe, rel, acc;
    if (rst_n && rd_req0 && rd_ack) hs_cnt++;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      hs  = m_rdreq && rd_ack;
      wr  = write_now();
      ld  = wr && m_col == HRES - 1;
      fe  = ld && m_row == VRES - 1;
      rel = line_release && m_lines > 0;
      acc = pix_valid && m_resv > 0;
      if ((pix_valid && m_resv == 0) || (line_release && m_lines == 0)) m_err = 1;
      m_rdreq = !hs && (m_occ + BURST <= DEPTH) && (m_reqs > 0);
      m_occ  = m_occ + (hs ? BURST : 0) - (rel ? HRES : 0);
      m_resv = m_resv + (hs ? BURST : 0) - (acc ? 1 : 0);
      if (fe) m_reqs = TOTAL;
      else if (hs) m_reqs--;
      if (ld && !rel) m_lines++;
      else if (rel && !ld) m_lines--;
      if (wr) begin
        void'(wq.pop_front());
        m_addr = (m_addr + 1) % DEPTH;
        if (ld) begin m_col = 0; m_row = (m_row + 1) % VRES; end
        else m_col++;
        if (fe) m_frames++;
      end
      cyc++;
      if (acc) wq.push_back('{cyc + 1, ref_grey(0, int'(pix_data)),
                              ref_grey(1, int'(pix_data)), ref_grey(2, int'(pix_data))});
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    pix_valid = 0; line_release = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_release();
    line_release = 1; tick(); line_release = 0;
  endtask

  initial begin
    int h0, prev, hs_at_frame;
    bit found;
    tab[0] = '{16'hFFFF, 8'd249, 8'd250, 8'd255};
    tab[1] = '{16'hF800, 8'd82,  8'd74,  8'd0};
    tab[2] = '{16'h07E0, 8'd84,  8'd147, 8'd224};
    tab[3] = '{16'h001F, 8'd82,  8'd28,  8'd31};
    tab[4] = '{16'h0000, 8'd0,   8'd0,   8'd0};
    tab[5] = '{16'h8410, 8'd128, 8'd128, 8'd16};
    tab[6] = '{16'h1234, 8'd81,  8'd62,  8'd52};

    m_frames = 0;
    rst_n = 0; pix_valid = 0; pix_data = '0; rd_ack = 0; line_release = 0;
    model_reset();
    idle(3);
    chk("rd_len_reset", int'(rd_len0), BURST);
    chk("addr_reset", int'(addr0), 0);
    chk("data_reset", int'(data0), 0);
    rst_n = 1;

    // Idle with the master acking everything: ring depth allows four bursts
    rd_ack = 1;
    h0 = hs_cnt;
    idle(20);
    chk("idle_handshakes", hs_cnt - h0, 4);
    chk("idle_rd_req_low", int'(rd_req0), 0);

    foreach (tab[i]) begin
      pix_data = tab[i].pix; pix_valid = 1; tick();
      pix_valid = 0; tick();
      chk("tab_we", int'(we0), 1);
      chk("tab_mean", int'(data0), int'(tab[i].e0));
      chk("tab_luma", int'(data1), int'(tab[i].e1));
      chk("tab_pass", int'(data2), int'(tab[i].e2));
    end

    pix_data = 16'hFFFF;
    for (int i = 0; i < DEPTH - 7; i++) begin pix_valid = 1; tick(); end
    idle(4);
    chk("lines_full", int'(lines0), 2);
    chk("wnd_full", int'(wnd0), 1);

    // No reservation left: pixel must be dropped and flagged
    pix_data = 16'h5555; pix_valid = 1; tick();
    idle(3);
    chk("err_drop", int'(err0), 1);

    pulse_release();
    chk("lines_after_rel", int'(lines0), 1);
    h0 = hs_cnt;
    idle(10);
    chk("rel_handshakes", hs_cnt - h0, 2);
    for (int i = 0; i < HRES; i++) begin
      pix_data = 16'($urandom); pix_valid = 1; tick();
    end
    idle(4);

    // Release on the same cycle a line completes
    pulse_release();
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      pix_data = 16'($urandom);
      pix_valid = (m_resv > 0);
      line_release = 0;
      if (write_now() && m_col == HRES - 1 && m_lines > 0) begin
        line_release = 1; found = 1; prev = m_lines;
      end
      tick();
      if (found) chk("lines_simul", int'(lines0), prev);
    end
    line_release = 0;
    if (!found) chk("simul_reached", 0, 1);

    hs_at_frame = -1;
    for (int i = 0; i < 700; i++) begin
      rd_ack = 1'($urandom_range(0, 1));
      pix_data = 16'($urandom);
      pix_valid = (m_resv > 0) && ($urandom_range(0, 3) != 0);
      line_release = (m_lines > 0) && ($urandom_range(0, 5) == 0);
      tick();
      if (fd0 && hs_at_frame < 0) hs_at_frame = hs_cnt;
    end
    idle(4);
    chk("frame_count", dut_frames, m_frames);
    chk("frames_seen", int'(m_frames >= 2), 1);
    chk("req_resume", int'(hs_at_frame >= 0 && hs_cnt > hs_at_frame), 1);

    // Asynchronous reset mid-burst
    rd_ack = 1;
    for (int i = 0; i < 6; i++) begin pix_data = 16'($urandom); pix_valid = (m_resv > 0); tick(); end
    rst_n = 0;
    #1;
    chk("arst_rd_req", int'(rd_req0), 0);
    chk("arst_we", int'(we0), 0);
    chk("arst_addr", int'(addr0), 0);
    chk("arst_data", int'(data0) + int'(data1) + int'(data2), 0);
    chk("arst_lines", int'(lines0), 0);
    chk("arst_wnd", int'(wnd0), 0);
    chk("arst_fd", int'(fd0), 0);
    chk("arst_err", int'(err0), 0);
    chk("arst_rd_len", int'(rd_len0), BURST);
    model_reset();
    idle(2);
    rst_n = 1;
    h0 = hs_cnt;
    idle(20);
    chk("post_rst_handshakes", hs_cnt - h0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
